// File: rtl/alarm_set_ctrl.sv
// Button-driven setting controller for the alarm clock datapath: edit FSM with
// inactivity timeout, user alarm storage, snooze/dismiss reload scheduling.
module alarm_set_ctrl #(
    parameter int unsigned SNOOZE_MIN = 5,
    parameter int unsigned TIMEOUT_S  = 30
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       tick_1s,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic       btn_set,
    input  logic       btn_snooze,
    input  logic [1:0] cur_h1,
    input  logic [3:0] cur_h0,
    input  logic [3:0] cur_m1,
    input  logic [3:0] cur_m0,
    input  logic       alarm_ring,
    output logic [1:0] H_in1,
    output logic [3:0] H_in0,
    output logic [3:0] M_in1,
    output logic [3:0] M_in0,
    output logic       LD_time,
    output logic       LD_alarm,
    output logic       Alarm_ON,
    output logic       STOP_alarm,
    output logic [2:0] edit_state
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        T_HOUR = 3'd1,
        T_MIN  = 3'd2,
        A_HOUR = 3'd3,
        A_MIN  = 3'd4
    } state_t;

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_S - 1);

    state_t     state_q, state_d;
    logic [5:0] eh_q, eh_d;       // {h1, h0} BCD
    logic [7:0] em_q, em_d;       // {m1, m0} BCD
    logic [5:0] ah_q, ah_d;
    logic [7:0] am_q, am_d;
    logic [5:0] hout_q, hout_d;
    logic [7:0] mout_q, mout_d;
    logic       ld_time_q, ld_time_d;
    logic       ld_alarm_q, ld_alarm_d;
    logic       stop_q, stop_d;
    logic       alarm_on_q, alarm_on_d;
    logic       snoozed_q, snoozed_d;
    logic [7:0] tmo_q, tmo_d;

    logic p_snooze, p_set, p_mode, p_inc, any_btn;
    logic [5:0] cur_h;
    logic [7:0] cur_m;

    assign cur_h    = {cur_h1, cur_h0};
    assign cur_m    = {cur_m1, cur_m0};
    assign any_btn  = btn_mode | btn_inc | btn_set | btn_snooze;
    assign p_snooze = btn_snooze;
    assign p_set    = btn_set & ~btn_snooze;
    assign p_mode   = btn_mode & ~btn_set & ~btn_snooze;
    assign p_inc    = btn_inc & ~btn_mode & ~btn_set & ~btn_snooze;

    function automatic logic [5:0] inc_hour(input logic [5:0] h);
        if (h == 6'h23)
            return '0;
        else if (h[3:0] == 4'd9)
            return {h[5:4] + 2'd1, 4'd0};
        else
            return {h[5:4], h[3:0] + 4'd1};
    endfunction

    function automatic logic [7:0] inc_min(input logic [7:0] m);
        if (m == 8'h59)
            return '0;
        else if (m[3:0] == 4'd9)
            return {m[7:4] + 4'd1, 4'd0};
        else
            return {m[7:4], m[3:0] + 4'd1};
    endfunction

    // Snooze target: current time plus SNOOZE_MIN, done in binary then back to BCD.
    logic [6:0] snz_min, snz_hr;
    logic [5:0] snz_h;
    logic [7:0] snz_m;

    always_comb begin
        snz_min = 7'(cur_m1) * 7'd10 + 7'(cur_m0) + 7'(SNOOZE_MIN);
        snz_hr  = 7'(cur_h1) * 7'd10 + 7'(cur_h0);
        if (snz_min >= 7'd60) begin
            snz_min = snz_min - 7'd60;
            snz_hr  = snz_hr + 7'd1;
        end
        if (snz_hr >= 7'd24)
            snz_hr = snz_hr - 7'd24;
        snz_h = {2'(snz_hr / 7'd10), 4'(snz_hr % 7'd10)};
        snz_m = {4'(snz_min / 7'd10), 4'(snz_min % 7'd10)};
    end

    always_comb begin
        state_d    = state_q;
        eh_d       = eh_q;
        em_d       = em_q;
        ah_d       = ah_q;
        am_d       = am_q;
        hout_d     = hout_q;
        mout_d     = mout_q;
        ld_time_d  = 1'b0;
        ld_alarm_d = 1'b0;
        stop_d     = 1'b0;
        alarm_on_d = alarm_on_q;
        snoozed_d  = snoozed_q;
        tmo_d      = tmo_q;

        if (alarm_ring) begin
            state_d = IDLE;
            tmo_d   = '0;
            if (p_snooze) begin
                stop_d     = 1'b1;
                ld_alarm_d = 1'b1;
                hout_d     = snz_h;
                mout_d     = snz_m;
                snoozed_d  = 1'b1;
            end else if (p_set) begin
                stop_d     = 1'b1;
                ld_alarm_d = 1'b1;
                hout_d     = ah_q;
                mout_d     = am_q;
                snoozed_d  = 1'b0;
            end
        end else begin
            // Buttons win over an expiring tick, so timeout never races a transition.
            if (state_q != IDLE) begin
                if (any_btn)
                    tmo_d = '0;
                else if (tick_1s) begin
                    if (tmo_q == TMO_LAST) begin
                        state_d = IDLE;
                        tmo_d   = '0;
                    end else
                        tmo_d = tmo_q + 8'd1;
                end
            end

            case (state_q)
                IDLE: begin
                    if (p_mode) begin
                        state_d = T_HOUR;
                        eh_d    = cur_h;
                        em_d    = cur_m;
                        tmo_d   = '0;
                    end else if (p_set) begin
                        alarm_on_d = ~alarm_on_q;
                        if (alarm_on_q && snoozed_q) begin
                            ld_alarm_d = 1'b1;
                            hout_d     = ah_q;
                            mout_d     = am_q;
                            snoozed_d  = 1'b0;
                        end
                    end
                end
                T_HOUR, A_HOUR: begin
                    if (p_set)
                        state_d = (state_q == T_HOUR) ? T_MIN : A_MIN;
                    else if (p_mode) begin
                        if (state_q == T_HOUR) begin
                            state_d = A_HOUR;
                            eh_d    = ah_q;
                            em_d    = am_q;
                        end else
                            state_d = IDLE;
                    end else if (p_inc)
                        eh_d = inc_hour(eh_q);
                end
                T_MIN, A_MIN: begin
                    if (p_set) begin
                        state_d = IDLE;
                        hout_d  = eh_q;
                        mout_d  = em_q;
                        if (state_q == T_MIN)
                            ld_time_d = 1'b1;
                        else begin
                            ld_alarm_d = 1'b1;
                            ah_d       = eh_q;
                            am_d       = em_q;
                            alarm_on_d = 1'b1;
                        end
                    end else if (p_mode) begin
                        if (state_q == T_MIN) begin
                            state_d = A_HOUR;
                            eh_d    = ah_q;
                            em_d    = am_q;
                        end else
                            state_d = IDLE;
                    end else if (p_inc)
                        em_d = inc_min(em_q);
                end
                default: begin
                    state_d = IDLE;
                    tmo_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            eh_q       <= '0;
            em_q       <= '0;
            ah_q       <= '0;
            am_q       <= '0;
            hout_q     <= '0;
            mout_q     <= '0;
            ld_time_q  <= 1'b0;
            ld_alarm_q <= 1'b0;
            stop_q     <= 1'b0;
            alarm_on_q <= 1'b0;
            snoozed_q  <= 1'b0;
            tmo_q      <= '0;
        end else begin
            state_q    <= state_d;
            eh_q       <= eh_d;
            em_q       <= em_d;
            ah_q       <= ah_d;
            am_q       <= am_d;
            hout_q     <= hout_d;
            mout_q     <= mout_d;
            ld_time_q  <= ld_time_d;
            ld_alarm_q <= ld_alarm_d;
            stop_q     <= stop_d;
            alarm_on_q <= alarm_on_d;
            snoozed_q  <= snoozed_d;
            tmo_q      <= tmo_d;
        end
    end

    assign H_in1      = hout_q[5:4];
    assign H_in0      = hout_q[3:0];
    assign M_in1      = mout_q[7:4];
    assign M_in0      = mout_q[3:0];
    assign LD_time    = ld_time_q;
    assign LD_alarm   = ld_alarm_q;
    assign STOP_alarm = stop_q;
    assign Alarm_ON   = alarm_on_q;
    assign edit_state = state_q;

endmodule
